// File: rtl/core_monitor_pkg.sv
// -----------------------------------------------------------------------------
// core_monitor_pkg
// Shared definitions for the N-core run-completion monitor:
//   - core_state_e : per-core lifecycle (idle, running, draining, done)
//   - SAT_INC      : step applied by the saturating run-cycle counter
//   - idx_width()  : clog2-based width with a floor of one bit, used for the
//                    report core index and the drain down-counter
// -----------------------------------------------------------------------------
package core_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } core_state_e;

    localparam int unsigned SAT_INC = 32'd1;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_completion_fsm.sv
// -----------------------------------------------------------------------------
// core_completion_fsm
// Tracks one core from an accepted start to completion. Counts run cycles
// until the core's PC reaches its end address (or the optional timeout
// expires), waits a fixed drain interval so the pipeline can retire, then
// samples the result register and compares it with the expected value.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   start_acc_i    accepted start pulse (only asserted when no core is busy)
//   pc_i           this core's current fetch PC
//   end_address_i  this core's finish PC
//   result_i       this core's result register
//   expected_i     this core's pass value
//   busy_o         core is in RUN or DRAIN
//   done_o         core has completed (held until next accepted start)
//   pass_o         result matched expected (valid with done_o)
//   timeout_o      run limit expired before the end address was reached
//   run_cycles_o   latched run length in cycles
//   done_entry_o   single-cycle flag: DONE is entered at the coming edge
// -----------------------------------------------------------------------------
module core_completion_fsm
    import core_monitor_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS   = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CYCLE_BITS     = 32,
    parameter int unsigned DRAIN_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_acc_i,
    input  logic [ADDRESS_BITS-1:0] pc_i,
    input  logic [ADDRESS_BITS-1:0] end_address_i,
    input  logic [DATA_WIDTH-1:0]   result_i,
    input  logic [DATA_WIDTH-1:0]   expected_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [CYCLE_BITS-1:0]   run_cycles_o,
    output logic                    done_entry_o
);

    localparam int unsigned           DRAIN_W      = idx_width(DRAIN_CYCLES + 32'd1);
    // Loaded with DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES - 32'd1);
    localparam logic [CYCLE_BITS-1:0] CNT_MAX      = {CYCLE_BITS{1'b1}};
    localparam bit                    TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CYCLE_BITS-1:0] TIMEOUT_LAST = TIMEOUT_EN ? CYCLE_BITS'(TIMEOUT_CYCLES - 32'd1)
                                                                : {CYCLE_BITS{1'b0}};
    localparam logic [CYCLE_BITS-1:0] TIMEOUT_VAL  = CYCLE_BITS'(TIMEOUT_CYCLES);

    core_state_e             state_q, state_d;
    logic [CYCLE_BITS-1:0]   cnt_q, cnt_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [CYCLE_BITS-1:0]   runc_q, runc_d;

    // Next-state, counter and flag logic for one core.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        runc_d    = runc_q;
        if (start_acc_i) begin
            state_d   = ST_RUN;
            cnt_d     = {CYCLE_BITS{1'b0}};
            drain_d   = {DRAIN_W{1'b0}};
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            runc_d    = {CYCLE_BITS{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = {CYCLE_BITS{1'b0}};
                end
                ST_RUN: begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CYCLE_BITS'(SAT_INC);
                    // PC match is checked first so it wins over a same-cycle timeout.
                    if (pc_i == end_address_i) begin
                        runc_d  = cnt_q;
                        drain_d = DRAIN_LOAD;
                        state_d = ST_DRAIN;
                    end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                        runc_d    = TIMEOUT_VAL;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == {DRAIN_W{1'b0}}) begin
                        pass_d  = (result_i == expected_i);
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and completion flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CYCLE_BITS{1'b0}};
            drain_q   <= {DRAIN_W{1'b0}};
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            runc_q    <= {CYCLE_BITS{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            runc_q    <= runc_d;
        end
    end

    assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_entry_o = (state_q != ST_DONE) && (state_d == ST_DONE);
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign run_cycles_o = runc_q;

endmodule

// File: rtl/core_completion_monitor.sv
// -----------------------------------------------------------------------------
// core_completion_monitor
// Watches NUM_CORES cores for completion and reports one record per finished
// core over a valid/ready port, lowest pending core index first.
//
// Ports
//   clk_i / rst_i       clock and synchronous active-high reset
//   start_i             one-cycle pulse arming all cores (ignored while busy)
//   end_address_i       per-core finish PC, slice i = core i
//   pc_i                per-core current PC
//   result_i            per-core result register
//   expected_i          per-core pass value
//   core_done_o         per-core completion flag
//   core_pass_o         per-core pass flag
//   core_timeout_o      per-core timeout flag
//   run_cycles_o        per-core latched run length
//   all_done_o          every core done
//   all_pass_o          every core done and passed
//   report_valid_o      a completion record is presented
//   report_ready_i      consumer accepts the record
//   report_core_o       core index of the record
//   report_cycles_o     run length of that core
//   report_pass_o       pass flag of that core
//   report_timeout_o    timeout flag of that core
// -----------------------------------------------------------------------------
module core_completion_monitor
    import core_monitor_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned ADDRESS_BITS   = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CYCLE_BITS     = 32,
    parameter int unsigned DRAIN_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned IDX_W          = idx_width(NUM_CORES)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] end_address_i,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] pc_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   result_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   expected_i,
    output logic [NUM_CORES-1:0]              core_done_o,
    output logic [NUM_CORES-1:0]              core_pass_o,
    output logic [NUM_CORES-1:0]              core_timeout_o,
    output logic [NUM_CORES*CYCLE_BITS-1:0]   run_cycles_o,
    output logic                              all_done_o,
    output logic                              all_pass_o,
    output logic                              report_valid_o,
    input  logic                              report_ready_i,
    output logic [IDX_W-1:0]                  report_core_o,
    output logic [CYCLE_BITS-1:0]             report_cycles_o,
    output logic                              report_pass_o,
    output logic                              report_timeout_o
);

    logic [NUM_CORES-1:0]  busy_s;
    logic [NUM_CORES-1:0]  done_entry_s;
    logic [CYCLE_BITS-1:0] runc_a [NUM_CORES];
    logic                  start_acc_s;

    logic [NUM_CORES-1:0]  pending_q, pending_d;
    logic [NUM_CORES-1:0]  ack_mask_s;
    logic                  lock_q;
    logic [IDX_W-1:0]      lock_idx_q;
    logic [IDX_W-1:0]      prio_idx_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic                  ack_s;

    // A start is taken only when every core is idle or done.
    assign start_acc_s = start_i & ~(|busy_s);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_completion_fsm #(
            .ADDRESS_BITS   (ADDRESS_BITS),
            .DATA_WIDTH     (DATA_WIDTH),
            .CYCLE_BITS     (CYCLE_BITS),
            .DRAIN_CYCLES   (DRAIN_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .start_acc_i   (start_acc_s),
            .pc_i          (pc_i[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .end_address_i (end_address_i[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .result_i      (result_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .expected_i    (expected_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o        (busy_s[i]),
            .done_o        (core_done_o[i]),
            .pass_o        (core_pass_o[i]),
            .timeout_o     (core_timeout_o[i]),
            .run_cycles_o  (runc_a[i]),
            .done_entry_o  (done_entry_s[i])
        );
        assign run_cycles_o[i*CYCLE_BITS +: CYCLE_BITS] = runc_a[i];
    end

    assign all_done_o = &core_done_o;
    assign all_pass_o = all_done_o & (&core_pass_o);

    // Lowest-index pending core; scanning downward lets the lowest index win.
    always_comb begin
        prio_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            prio_idx_s = pending_q[i] ? IDX_W'(i) : prio_idx_s;
        end
    end

    // While a stalled record is presented, keep pointing at it even if a
    // lower-index core completes meanwhile, so the fields stay stable.
    assign sel_idx_s        = lock_q ? lock_idx_q : prio_idx_s;
    assign report_valid_o   = |pending_q;
    assign ack_s            = report_valid_o & report_ready_i;
    assign report_core_o    = sel_idx_s;
    assign report_cycles_o  = runc_a[sel_idx_s];
    assign report_pass_o    = core_pass_o[sel_idx_s];
    assign report_timeout_o = core_timeout_o[sel_idx_s];

    // Pending-bit update: set on entry to DONE, cleared on acceptance.
    always_comb begin
        ack_mask_s = {NUM_CORES{1'b0}};
        if (ack_s) begin
            ack_mask_s[sel_idx_s] = 1'b1;
        end else begin
            ack_mask_s = {NUM_CORES{1'b0}};
        end
        pending_d = (pending_q | done_entry_s) & ~ack_mask_s;
    end

    // Pending vector and stall lock registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= {NUM_CORES{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {IDX_W{1'b0}};
        end else if (start_acc_s) begin
            pending_q  <= {NUM_CORES{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {IDX_W{1'b0}};
        end else begin
            pending_q  <= pending_d;
            lock_q     <= report_valid_o & ~report_ready_i;
            lock_idx_q <= sel_idx_s;
        end
    end

endmodule

// File: doc/core_completion_monitor.md
# core_completion_monitor

Synthesizable N-core run-completion monitor for the multi-core processor top. Each core's fetch PC is watched for a per-core end address. On a match, the core's run time in cycles is latched, a pipeline-drain interval is counted, then the core's result register is sampled and compared against an expected value. Completion records go out one at a time over a valid/ready report port, so on-chip logic or a bench logger sees per-core pass/fail/timeout without hierarchical probing.

## Interface
- NUM_CORES, 2, number of monitored cores (1..16)
- ADDRESS_BITS, 32, PC / end-address width
- DATA_WIDTH, 32, result and expected-value width
- CYCLE_BITS, 32, run-cycle counter width
- DRAIN_CYCLES, 50, cycles waited after PC match before sampling result (>=1)
- TIMEOUT_CYCLES, 0, per-core run limit; 0 disables timeout
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; arms all cores
- end_address  in  NUM_CORES*ADDRESS_BITS  per-core finish PC, slice i = core i
- PC  in  NUM_CORES*ADDRESS_BITS  per-core current PC
- result  in  NUM_CORES*DATA_WIDTH  per-core result register (e.g. x9)
- expected  in  NUM_CORES*DATA_WIDTH  per-core pass value
- core_done  out  NUM_CORES  core reached DONE
- core_pass  out  NUM_CORES  result matched expected (valid with core_done)
- core_timeout  out  NUM_CORES  core hit TIMEOUT_CYCLES
- run_cycles  out  NUM_CORES*CYCLE_BITS  latched cycle count per core
- all_done  out  1  &core_done
- all_pass  out  1  all_done & &core_pass
- report_valid  out  1  a completion record is presented
- report_ready  in  1  consumer accepts record
- report_core  out  clog2(NUM_CORES) (min 1)  core index of record
- report_cycles  out  CYCLE_BITS  run_cycles of that core
- report_pass  out  1  pass flag of that core
- report_timeout  out  1  timeout flag of that core

## Operation
- Per-core FSM: IDLE -> RUN -> DRAIN -> DONE.
- IDLE: waits for an accepted start; counter cleared.
- RUN: counter increments each cycle and saturates at all-ones.
  - PC == end_address: latch run_cycles = counter, enter DRAIN.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: enter DONE with timeout=1, pass=0, run_cycles = TIMEOUT_CYCLES.
  - PC match wins over timeout in the same cycle.
- DRAIN: down-counter from DRAIN_CYCLES; PC is ignored. At zero, sample result, pass = (result == expected), enter DONE.
- DONE: sets that core's pending-report bit on entry. Holds until the next accepted start or reset.
- start is accepted only when no core is in RUN or DRAIN. An accepted start clears done/pass/timeout/run_cycles and pending bits, and moves every core to RUN. start while busy is ignored.
- Report port: fixed priority, lowest pending index first.
  - report_valid is high while any pending bit is set.
  - Fields are stable while valid && !ready.
  - valid && ready clears that pending bit; the next record is presented the following cycle.
- Reset mid-operation: all outputs return to 0, all FSMs to IDLE, pending reports discarded.

## Timing
- Reset values: every output 0 (report_core 0).
- start high in cycle s: RUN in s+1, counter 0 in s+1.
- Match in cycle m gives run_cycles = m-(s+1).
- DRAIN occupies m+1..m+DRAIN_CYCLES. result is sampled at the edge ending m+DRAIN_CYCLES.
- core_done, core_pass and the pending bit are visible in m+DRAIN_CYCLES+1. report_valid rises in the same cycle if the port is free.
- all_done/all_pass are combinational from registered flags, with zero added latency.
- Two cores finishing in the same cycle: both pending; lower index reported first, higher index in the cycle after acceptance.

## Structure
- Package core_monitor_pkg: state enum (IDLE, RUN, DRAIN, DONE), a clog2-based index-width function, and a saturating-increment constant.
- Sub-module core_completion_fsm: one instance per core via generate, holding the FSM, counters and flags.
- Top holds start-accept logic, the pending vector, the priority encoder and the report mux.

## Test plan
- NUM_CORES=2, DRAIN_CYCLES=4, end 0xB0/0x168, start, then PC0=0xB0 at s+21 and PC1=0x168 at s+41 -> run_cycles 20/40, core_done0 at s+26, all_done at s+46, two reports in order.
- result0=0 vs expected 0, result1=5 vs expected 0 -> core_pass=01, all_pass=0, report_pass 1 then 0.
- Both PCs match in the same cycle, report_ready held low 3 cycles -> core 0 record held stable, core 1 presented one cycle after acceptance.
- TIMEOUT_CYCLES=100, core 1 never matches -> core_timeout1 at s+101, run_cycles1=100, pass 0.
- start pulsed during DRAIN -> ignored. Reset asserted mid-RUN -> all outputs 0 next cycle, a new start then runs cleanly.
- PC toggles onto end_address during DRAIN -> no re-latch, run_cycles unchanged.
